single_iamax_ctrl: RTL and testbench

- Sequences a streamed vector of IEEE-754 single-precision values through a magnitude comparator and finds the 0-based index of the element with the largest absolute value (BLAS isamax semantics).
- Holds the running maximum, its index and its sign.
- Sits between a vector source (FIFO/DMA reader) and a consumer of the scalar result.
- Throughput is one element per clock.

---
 rtl/single_pkg.sv | 34 +++
 rtl/single_abs_gt.sv | 29 ++
 rtl/single_iamax_ctrl.sv | 157 +++++++++++++++
 tb/tb_single_iamax_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/single_pkg.sv
// single_pkg: shared IEEE-754 single-precision field definitions and the
// iamax controller state type.
//
// Contents:
//   SGL_* constants   field boundaries of a single-precision word
//   sgl_t             packed view {sign, exp, man}
//   iamax_state_t     controller states IDLE / RUN / DONE
//   sgl_is_nan()      exp all-ones with a non-zero mantissa
package single_pkg;

    localparam int unsigned SGL_EXP_MSB  = 30;
    localparam int unsigned SGL_EXP_LSB  = 23;
    localparam int unsigned SGL_MAN_MSB  = 22;
    localparam logic [7:0]  SGL_EXP_ALL1 = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } sgl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iamax_state_t;

    function automatic logic sgl_is_nan(input logic [31:0] v);
        sgl_t s;
        s = v;
        return (s.exp == SGL_EXP_ALL1) && (s.man != '0);
    endfunction

endpackage

// File: rtl/single_abs_gt.sv
// single_abs_gt: combinational strict magnitude compare of two single-precision
// words. Sign bits are ignored; the exponent decides first, the mantissa
// breaks exponent ties. Usable by any max/min reducer.
//
// Ports:
//   a       [31:0]  reference value (e.g. running maximum)
//   b       [31:0]  candidate value
//   b_gt_a          1 when |b| > |a| strictly
module single_abs_gt
    import single_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        b_gt_a
);

    logic unused_sign;
    assign unused_sign = a[31] ^ b[31];

    always_comb begin
        b_gt_a = 1'b0;
        if (b[SGL_EXP_MSB:SGL_EXP_LSB] != a[SGL_EXP_MSB:SGL_EXP_LSB]) begin
            b_gt_a = b[SGL_EXP_MSB:SGL_EXP_LSB] > a[SGL_EXP_MSB:SGL_EXP_LSB];
        end else begin
            b_gt_a = b[SGL_MAN_MSB:0] > a[SGL_MAN_MSB:0];
        end
    end

endmodule

// File: rtl/single_iamax_ctrl.sv
// single_iamax_ctrl: scans a streamed vector of single-precision values, one
// element per clock, and reports the 0-based index, magnitude and sign of the
// first element with the largest absolute value (isamax semantics).
//
// Configuration macro: SINGLE_IAMAX_NAN_EN
//   defined   -> the first NaN wins and is locked; adds output nan_seen
//   undefined -> pure bit-magnitude compare, no nan_seen port
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, len                scan request and element count (IDLE only)
//   busy                      high in RUN and DONE
//   in_valid/in_ready/in_data element stream
//   out_valid/out_ready       result handshake
//   out_idx, out_max_abs,     result: index, magnitude (bit 31 = 0), sign
//   out_sign
//   nan_seen                  (macro only) a NaN was captured
module single_iamax_ctrl
    import single_pkg::*;
#(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned IDX_W = LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [31:0]      out_max_abs,
    output logic             out_sign
`ifdef SINGLE_IAMAX_NAN_EN
    ,
    output logic             nan_seen
`endif
);

    iamax_state_t     state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sign_q, sign_d;
    logic             gt;
    logic             better;
    logic             take;

    single_abs_gt u_abs_gt (
        .a      (max_q),
        .b      (in_data),
        .b_gt_a (gt)
    );

`ifdef SINGLE_IAMAX_NAN_EN
    logic nan_q, nan_d;
    // Once a NaN is held nothing replaces it; a new NaN beats any non-NaN.
    assign better   = !nan_q && (sgl_is_nan(in_data) || gt);
    assign nan_seen = nan_q && (state_q == DONE);
`else
    assign better = gt;
`endif

    // Element 0 always loads, so stale results never leak into a new scan.
    assign take = (cnt_q == '0) || better;

    assign busy        = (state_q != IDLE);
    assign in_ready    = (state_q == RUN);
    assign out_valid   = (state_q == DONE);
    assign out_idx     = idx_q;
    assign out_max_abs = max_q;
    assign out_sign    = sign_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        sign_d  = sign_q;
`ifdef SINGLE_IAMAX_NAN_EN
        nan_d   = nan_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SINGLE_IAMAX_NAN_EN
                    nan_d = 1'b0;
`endif
                    if (len != '0) begin
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d   = '0;
                        max_d   = '0;
                        sign_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (take) begin
                        max_d  = {1'b0, in_data[30:0]};
                        sign_d = in_data[31];
                        idx_d  = IDX_W'(cnt_q);
`ifdef SINGLE_IAMAX_NAN_EN
                        nan_d  = sgl_is_nan(in_data);
`endif
                    end
                    // Compare against len-1 so a full-range length never needs
                    // the counter to wrap before the last beat.
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            sign_q  <= 1'b0;
`ifdef SINGLE_IAMAX_NAN_EN
            nan_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            sign_q  <= sign_d;
`ifdef SINGLE_IAMAX_NAN_EN
            nan_q   <= nan_d;
`endif
        end
    end

endmodule

// File: tb/tb_single_iamax_ctrl.sv
// Self-checking bench for single_iamax_ctrl: directed scans plus randomized
// vectors compared against a simple array-based isamax reference.
module tb_single_iamax_ctrl;

    localparam int LEN_W = 16;
    localparam int IDX_W = 16;
`ifdef SINGLE_IAMAX_NAN_EN
    localparam bit NAN_MODE = 1'b1;
`else
    localparam bit NAN_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_idx;
    logic [31:0]      out_max_abs;
    logic             out_sign;
    logic             nan_obs;
`ifdef SINGLE_IAMAX_NAN_EN
    logic             nan_seen;
    assign nan_obs = nan_seen;
`else
    assign nan_obs = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] vec[$];

    single_iamax_ctrl #(
        .LEN_W (LEN_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_max_abs (out_max_abs),
        .out_sign    (out_sign)
`ifdef SINGLE_IAMAX_NAN_EN
        ,
        .nan_seen    (nan_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Does candidate x displace the current best under isamax rules?
    function automatic bit beats(input logic [31:0] x, input logic [31:0] best);
        if (NAN_MODE) begin
            if (is_nan(best)) return 1'b0;
            if (is_nan(x)) return 1'b1;
        end
        return (x & 32'h7FFF_FFFF) > (best & 32'h7FFF_FFFF);
    endfunction

    task automatic model(output int idx, output logic [31:0] mx, output bit sg, output bit nn);
        idx = 0;
        for (int i = 1; i < vec.size(); i++) begin
            if (beats(vec[i], vec[idx])) idx = i;
        end
        mx = vec[idx] & 32'h7FFF_FFFF;
        sg = vec[idx][31];
        nn = NAN_MODE && is_nan(vec[idx]);
    endtask

    // vmode: 0 continuous valid, 1 alternating, 2 random gaps.
    task automatic run_scan(input string name, input int vmode, input bit mid_start);
        int n, i, cyc, e_idx;
        bit acc, v, e_sg, e_nn;
        logic [31:0] e_mx;
        n = vec.size();
        model(e_idx, e_mx, e_sg, e_nn);
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_run"}, 64'(busy), 64'd1);
        i = 0;
        cyc = 0;
        while (i < n && cyc < 400) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? vec[i] : $urandom;
            if (mid_start && cyc == 3) begin
                start = 1'b1;
                len   = LEN_W'(1);
            end else begin
                start = 1'b0;
            end
            acc = v && in_ready;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < n) chk({name, "_beats_accepted"}, 64'(i), 64'(n));
        chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
        chk({name, "_idx"}, 64'(out_idx), 64'(e_idx));
        chk({name, "_max_abs"}, 64'(out_max_abs), 64'(e_mx));
        chk({name, "_sign"}, 64'(out_sign), 64'(e_sg));
        chk({name, "_nan_seen"}, 64'(nan_obs), 64'(e_nn));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk({name, "_valid_held"}, 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({name, "_busy_idle"}, 64'(busy), 64'd0);
        chk({name, "_idx_kept"}, 64'(out_idx), 64'(e_idx));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_idx"}, 64'(out_idx), 64'd0);
        chk({name, "_max_abs"}, 64'(out_max_abs), 64'd0);
        chk({name, "_sign"}, 64'(out_sign), 64'd0);
        chk({name, "_nan_seen"}, 64'(nan_obs), 64'd0);
    endtask

    logic [31:0] pool[9] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                             32'h7F80_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001,
                             32'h3F80_0001};

    initial begin
        // Reset state
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Mixed signs, tie between -3.0 and 3.0: earlier index wins
        vec = '{32'h3F80_0000, 32'hC040_0000, 32'h4040_0000, 32'h3F00_0000};
        run_scan("t1", 0, 1'b0);
        chk("t1_idx_const", 64'(out_idx), 64'd1);
        chk("t1_max_const", 64'(out_max_abs), 64'h4040_0000);
        chk("t1_sign_const", 64'(out_sign), 64'd1);

        // Signed zeros: first one wins with its sign
        vec = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        run_scan("t2", 0, 1'b0);
        chk("t2_sign_const", 64'(out_sign), 64'd1);

        // Zero-length scan, held result, start ignored in DONE
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("len0_valid", 64'(out_valid), 64'd1);
            chk("len0_result", {out_idx, out_max_abs, out_sign}, 64'd0);
            if (c == 2) begin
                start = 1'b1;
                len   = LEN_W'(7);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        chk("len0_start_dropped_busy", 64'(busy), 64'd0);
        chk("len0_start_dropped_valid", 64'(out_valid), 64'd0);

        // Toggling valid, +Inf last, start pulsed mid-scan
        vec = '{32'h3F80_0000, 32'h4000_0000, 32'hC080_0000, 32'h4040_0000, 32'h7F80_0000};
        run_scan("t4", 1, 1'b1);
        chk("t4_idx_const", 64'(out_idx), 64'd4);

        // Asynchronous reset mid-scan
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(6);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h4100_0000;
        @(negedge clk);
        in_data  = 32'hC200_0000;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        vec = '{32'h4000_0000, 32'h4080_0000};
        run_scan("t5", 0, 1'b0);
        chk("t5_idx_const", 64'(out_idx), 64'd1);
        chk("t5_max_const", 64'(out_max_abs), 64'h4080_0000);

        // NaN handling
        vec = '{32'h7F80_0000, 32'h7FC0_0001, 32'h7FFF_FFFF, 32'h3F80_0000};
        run_scan("t6", 0, 1'b0);
        chk("t6_idx_const", 64'(out_idx), NAN_MODE ? 64'd1 : 64'd2);

        // Randomized vectors
        for (int t = 0; t < 25; t++) begin
            int n;
            logic [31:0] w;
            n = $urandom_range(1, 10);
            vec.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 4) == 0) w = $urandom;
                else w = {1'($urandom_range(0, 1)), pool[$urandom_range(0, 8)][30:0]};
                vec.push_back(w);
            end
            run_scan($sformatf("rnd%0d", t), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
